// File: rtl/tk_pkg.sv
// Shared time-of-day types and BCD helpers for the alarm-clock datapath.
// Used by the timekeeper and the alarm-set validation logic.
package tk_pkg;

  localparam int BCD_W = 8;

  typedef logic [BCD_W-1:0] bcd_t;

  localparam bcd_t SS_MAX = 8'h59;
  localparam bcd_t MM_MAX = 8'h59;
  localparam bcd_t HH_MAX = 8'h23;

  typedef struct packed {
    bcd_t hh;
    bcd_t mm;
    bcd_t ss;
  } tod_t;

  // Both nibbles must be decimal; once they are, byte order equals BCD order.
  function automatic logic bcd_ok(input bcd_t v, input bcd_t max);
    return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v <= max);
  endfunction

  function automatic logic tod_ok(input tod_t t);
    return bcd_ok(t.hh, HH_MAX) && bcd_ok(t.mm, MM_MAX) && bcd_ok(t.ss, SS_MAX);
  endfunction

  // BCD +1 without field wrap; callers handle the max->00 case.
  function automatic bcd_t bcd_inc(input bcd_t v);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = v[7:4];
    lo = v[3:0];
    if (lo == 4'd9) begin
      hi = hi + 4'd1;
      lo = 4'd0;
    end else begin
      lo = lo + 4'd1;
    end
    return {hi, lo};
  endfunction

endpackage

// File: rtl/tick_sync_edge.sv
// Synchronizes the divider's slow clock into clk and emits one registered
// pulse per qualified edge, suppressed until the pipeline has filled.
module tick_sync_edge
  import tk_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_in,
  output logic edge_pulse
);

  localparam int AW = $clog2(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   hist;
  logic                   armed;
  logic [AW-1:0]          arm_cnt;
  logic                   last;
  logic                   raw_edge;

  assign last = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync <= '0;
      hist <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], tick_in};
      hist <= last;
    end
  end

  // Arms once the history flop holds a synchronized sample, so a level that
  // was already high at reset never looks like an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      arm_cnt <= '0;
      armed   <= 1'b0;
    end else if (!armed) begin
      if (arm_cnt == AW'(SYNC_STAGES)) armed <= 1'b1;
      else                             arm_cnt <= arm_cnt + 1'b1;
    end
  end

  always_comb begin
    raw_edge = last & ~hist;
    if (EDGE_MODE != 0) raw_edge = last ^ hist;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) edge_pulse <= 1'b0;
    else      edge_pulse <= armed & raw_edge;
  end

endmodule

// File: rtl/tick_timekeeper.sv
// BCD hh:mm:ss time of day driven by the synchronized divider tick, with
// validated synchronous load and a sticky lost-tick watchdog.
module tick_timekeeper
  import tk_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = 0,
  parameter int TIMEOUT     = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_in,
  input  logic       set_valid,
  input  logic [7:0] set_hh,
  input  logic [7:0] set_mm,
  input  logic [7:0] set_ss,
  input  logic       tick_lost_clr,
  output logic       tick,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       min_roll,
  output logic       day_roll,
  output logic       load_err,
  output logic       tick_lost
);

  localparam int WD_W = $clog2(TIMEOUT);

  tod_t            tod;
  tod_t            set_tod;
  logic            set_ok;
  logic            ss_wrap;
  logic            mm_wrap;
  logic            hh_wrap;
  logic [WD_W-1:0] wd_cnt;
  logic            wd_hit;

  tick_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES),
    .EDGE_MODE  (EDGE_MODE)
  ) u_sync (
    .clk       (clk),
    .rst       (rst),
    .tick_in   (tick_in),
    .edge_pulse(tick)
  );

  assign set_tod = '{hh: set_hh, mm: set_mm, ss: set_ss};
  assign set_ok  = tod_ok(set_tod);

  assign ss_wrap = (tod.ss == SS_MAX);
  assign mm_wrap = (tod.mm == MM_MAX);
  assign hh_wrap = (tod.hh == HH_MAX);

  assign hh = tod.hh;
  assign mm = tod.mm;
  assign ss = tod.ss;

  // A load owns the cycle: a coincident tick is dropped, not deferred.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tod      <= '0;
      min_roll <= 1'b0;
      day_roll <= 1'b0;
      load_err <= 1'b0;
    end else begin
      min_roll <= 1'b0;
      day_roll <= 1'b0;
      load_err <= 1'b0;
      if (set_valid) begin
        if (set_ok) tod      <= set_tod;
        else        load_err <= 1'b1;
      end else if (tick) begin
        if (ss_wrap) begin
          tod.ss   <= '0;
          min_roll <= 1'b1;
          if (mm_wrap) begin
            tod.mm <= '0;
            if (hh_wrap) begin
              tod.hh   <= '0;
              day_roll <= 1'b1;
            end else begin
              tod.hh <= bcd_inc(tod.hh);
            end
          end else begin
            tod.mm <= bcd_inc(tod.mm);
          end
        end else begin
          tod.ss <= bcd_inc(tod.ss);
        end
      end
    end
  end

  assign wd_hit = (wd_cnt == WD_W'(TIMEOUT - 1));

  // Counter saturates at the limit, so the set condition keeps winning over a
  // clear until a tick (or a clear) restarts the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt    <= '0;
      tick_lost <= 1'b0;
    end else begin
      if (tick || tick_lost_clr) wd_cnt <= '0;
      else if (!wd_hit)          wd_cnt <= wd_cnt + 1'b1;

      if (wd_hit)             tick_lost <= 1'b1;
      else if (tick_lost_clr) tick_lost <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tick_timekeeper.sv
// Randomized scoreboard bench: stimulus pushes expected time/roll/load results
// from a seconds-of-day model; a negedge monitor pops and compares them.
module tb_tick_timekeeper;

  logic       clk;
  logic       rst;
  logic       rst_b;
  logic       tick_in;
  logic       set_valid;
  logic [7:0] set_hh, set_mm, set_ss;
  logic       tick_lost_clr;

  logic       tick, min_roll, day_roll, load_err, tick_lost;
  logic [7:0] hh, mm, ss;
  logic       tick_b, min_roll_b, day_roll_b, load_err_b, tick_lost_b;
  logic [7:0] hh_b, mm_b, ss_b;

  tick_timekeeper #(.SYNC_STAGES(2), .EDGE_MODE(0), .TIMEOUT(10)) dut (
    .clk(clk), .rst(rst), .tick_in(tick_in), .set_valid(set_valid),
    .set_hh(set_hh), .set_mm(set_mm), .set_ss(set_ss),
    .tick_lost_clr(tick_lost_clr), .tick(tick), .hh(hh), .mm(mm), .ss(ss),
    .min_roll(min_roll), .day_roll(day_roll), .load_err(load_err),
    .tick_lost(tick_lost)
  );

  tick_timekeeper #(.SYNC_STAGES(3), .EDGE_MODE(1), .TIMEOUT(1000)) dut_b (
    .clk(clk), .rst(rst_b), .tick_in(tick_in), .set_valid(1'b0),
    .set_hh(set_hh), .set_mm(set_mm), .set_ss(set_ss),
    .tick_lost_clr(1'b0), .tick(tick_b), .hh(hh_b), .mm(mm_b), .ss(ss_b),
    .min_roll(min_roll_b), .day_roll(day_roll_b), .load_err(load_err_b),
    .tick_lost(tick_lost_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [7:0] hh, mm, ss; logic mr, dr; } exp_t;
  typedef struct { logic [7:0] hh, mm, ss; logic err; } ld_t;

  exp_t tq[$];
  ld_t  lq[$];
  int   secs;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic mon_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  function automatic int from_bcd(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic bit field_ok(input logic [7:0] b, input int lim);
    return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9) && (from_bcd(b) <= lim);
  endfunction

  // Seconds-of-day model: a counted tick adds one second modulo a day.
  task automatic model_tick();
    exp_t e;
    secs = (secs + 1) % 86400;
    e.hh = to_bcd(secs / 3600);
    e.mm = to_bcd((secs / 60) % 60);
    e.ss = to_bcd(secs % 60);
    e.mr = (secs % 60 == 0);
    e.dr = (secs == 0);
    tq.push_back(e);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rise(input int w);
    tick_in = 1'b1;
    model_tick();
    cyc(w);
  endtask

  task automatic fall(input int w);
    tick_in = 1'b0;
    cyc(w);
  endtask

  // Drives a one-cycle load; leaves the bench one cycle later.
  task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    ld_t l;
    bit  ok;
    ok = field_ok(h, 23) && field_ok(m, 59) && field_ok(s, 59);
    if (ok) secs = from_bcd(h) * 3600 + from_bcd(m) * 60 + from_bcd(s);
    l.hh  = to_bcd(secs / 3600);
    l.mm  = to_bcd((secs / 60) % 60);
    l.ss  = to_bcd(secs % 60);
    l.err = !ok;
    lq.push_back(l);
    set_hh = h; set_mm = m; set_ss = s;
    set_valid = 1'b1;
    cyc(1);
    set_valid = 1'b0;
  endtask

  // Rising edge whose tick lands in the same cycle as a load strobe.
  task automatic rise_with_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    tick_in = 1'b1;
    cyc(3);
    do_load(h, m, s);
    cyc(3);
  endtask

  logic pend_t = 1'b0;
  logic pend_l = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    ld_t  l;
    if (!mon_en) begin
      pend_t = 1'b0;
      pend_l = 1'b0;
    end else begin
      if (pend_t) begin
        chk("tick_expected", 64'(tq.size() != 0), 64'd1);
        if (tq.size() != 0) begin
          e = tq.pop_front();
          chk("tick_time", {hh, mm, ss}, {e.hh, e.mm, e.ss});
          chk("tick_rolls", {min_roll, day_roll}, {e.mr, e.dr});
        end
      end else begin
        chk("idle_rolls", {min_roll, day_roll}, 64'd0);
      end
      if (pend_l) begin
        chk("load_expected", 64'(lq.size() != 0), 64'd1);
        if (lq.size() != 0) begin
          l = lq.pop_front();
          chk("load_time", {hh, mm, ss}, {l.hh, l.mm, l.ss});
          chk("load_err", load_err, l.err);
        end
      end else begin
        chk("idle_load_err", load_err, 64'd0);
      end
      pend_t = tick && !set_valid;
      pend_l = set_valid;
    end
  end

  initial begin
    rst = 1'b0; rst_b = 1'b0; tick_in = 1'b1; set_valid = 1'b0;
    set_hh = 8'h00; set_mm = 8'h00; set_ss = 8'h00; tick_lost_clr = 1'b0;
    secs = 0;
    cyc(3);
    chk("reset_outputs", {tick, hh, mm, ss, min_roll, day_roll, load_err, tick_lost}, 64'd0);

    // tick_in already high at reset release must not tick
    rst = 1'b1; rst_b = 1'b1; mon_en = 1'b1;
    cyc(20);
    chk("held_high_time", {hh, mm, ss}, 64'd0);
    fall(6);

    // single edge latency: tick in cycle 3, new ss in cycle 4
    tick_in = 1'b1;
    model_tick();
    for (int c = 1; c <= 4; c++) begin
      cyc(1);
      if (c < 3)  chk("latency_tick_early", tick, 64'd0);
      if (c == 3) chk("latency_tick", tick, 64'd1);
      if (c == 4) chk("latency_ss", ss, 64'h01);
    end
    cyc(2);
    fall(6);

    // day wrap
    do_load(8'h23, 8'h59, 8'h58);
    cyc(2);
    rise(5); fall(5); rise(5);
    chk("day_wrap_time", {hh, mm, ss}, 64'd0);
    fall(5);

    // load validation and load-beats-tick
    do_load(8'h10, 8'h20, 8'h30); cyc(2);
    do_load(8'h24, 8'h00, 8'h00); cyc(2);
    do_load(8'h12, 8'h3A, 8'h00); cyc(2);
    chk("illegal_unchanged", {hh, mm, ss}, 64'h102030);
    rise_with_load(8'h12, 8'h34, 8'h56);
    chk("load_beats_tick", {hh, mm, ss}, 64'h123456);
    fall(5);

    // randomized mix
    for (int i = 0; i < 80; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 4) begin
        if (tick_in) fall(5);
        else         rise(5);
      end else if (r <= 6) begin
        do_load(to_bcd($urandom_range(0, 23)), to_bcd($urandom_range(0, 59)),
                to_bcd($urandom_range(0, 59)));
        cyc(2);
      end else if (r == 7) begin
        do_load(8'($urandom), 8'($urandom), 8'($urandom));
        cyc(2);
      end else if (r == 8) begin
        if (tick_in) fall(5);
        else rise_with_load(to_bcd($urandom_range(0, 23)), to_bcd($urandom_range(0, 59)),
                            to_bcd($urandom_range(0, 59)));
      end else begin
        do_load(to_bcd($urandom_range(0, 23)), 8'h59, to_bcd($urandom_range(58, 59)));
        cyc(2);
      end
    end
    if (tick_in) fall(6);
    cyc(4);

    // watchdog from a fresh reset, no edges
    chk("queues_drained", 64'(tq.size() + lq.size()), 64'd0);
    mon_en = 1'b0;
    rst = 1'b0;
    cyc(2);
    chk("reset_outputs_2", {tick, hh, mm, ss, min_roll, day_roll, load_err, tick_lost}, 64'd0);
    rst = 1'b1; secs = 0; mon_en = 1'b1;
    cyc(9);
    chk("wd_before_timeout", tick_lost, 64'd0);
    cyc(1);
    chk("wd_timeout", tick_lost, 64'd1);
    tick_lost_clr = 1'b1;
    cyc(1);
    chk("wd_clr_vs_saturated", tick_lost, 64'd1);
    cyc(1);
    tick_lost_clr = 1'b0;
    chk("wd_clr", tick_lost, 64'd0);
    cyc(9);
    chk("wd_before_retimeout", tick_lost, 64'd0);
    tick_lost_clr = 1'b1;
    cyc(1);
    tick_lost_clr = 1'b0;
    chk("wd_set_wins", tick_lost, 64'd1);
    for (int i = 0; i < 3; i++) begin rise(4); fall(4); end
    chk("wd_sticky", tick_lost, 64'd1);
    tick_lost_clr = 1'b1;
    cyc(1);
    tick_lost_clr = 1'b0;
    chk("wd_clr_running", tick_lost, 64'd0);
    rise(4); fall(4);
    chk("wd_stays_clear", tick_lost, 64'd0);

    // both-edge instance
    rst_b = 1'b0;
    cyc(2);
    chk("b_reset_outputs", {tick_b, hh_b, mm_b, ss_b, min_roll_b, day_roll_b, load_err_b, tick_lost_b}, 64'd0);
    rst_b = 1'b1;
    cyc(5);
    tick_in = 1'b1;
    model_tick();
    for (int c = 1; c <= 4; c++) begin
      cyc(1);
      if (c < 4) chk("b_latency_early", tick_b, 64'd0);
      else       chk("b_latency_tick", tick_b, 64'd1);
    end
    cyc(4);
    fall(8); rise(8); fall(8);
    chk("b_both_edges", ss_b, 64'h04);
    rise(4);
    rst_b = 1'b0;
    #1;
    chk("b_mid_reset", {tick_b, hh_b, mm_b, ss_b, min_roll_b, day_roll_b, load_err_b, tick_lost_b}, 64'd0);
    cyc(1);
    rst_b = 1'b1;
    cyc(6);
    fall(6);
    cyc(4);

    mon_en = 1'b0;
    chk("all_results_seen", 64'(tq.size() + lq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tick_timekeeper.md
# tick_timekeeper

Consumes the slow toggling clock produced by the design's clock divider and turns it into a clean, single-cycle tick enable in the fast `clk` domain. It maintains BCD hours/minutes/seconds time of day for the alarm-clock datapath. It supports synchronous time loading and flags a lost or stalled tick source. It sits between the divider and the display/alarm-compare logic.

## Interface
- `SYNC_STAGES`, 2: synchronizer depth on `tick_in`; legal values are 2..4.
- `EDGE_MODE`, 0: 0 counts rising edges of `tick_in` only; 1 counts both edges.
- `TIMEOUT`, 100_000_000: `clk` cycles without a tick before `tick_lost` sets; minimum 4.
- `clk` input 1: system clock; all logic is on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `tick_in` input 1: divider output, treated as asynchronous to `clk`.
- `set_valid` input 1: one-cycle load strobe.
- `set_hh` input 8: BCD hours to load (00-23).
- `set_mm` input 8: BCD minutes to load (00-59).
- `set_ss` input 8: BCD seconds to load (00-59).
- `tick_lost_clr` input 1: clears `tick_lost`.
- `tick` output 1: one-cycle pulse per counted edge.
- `hh` output 8: current BCD hours.
- `mm` output 8: current BCD minutes.
- `ss` output 8: current BCD seconds.
- `min_roll` output 1: one-cycle pulse when `ss` wraps from 59 to 00.
- `day_roll` output 1: one-cycle pulse when the time wraps from 23:59:59 to 00:00:00.
- `load_err` output 1: one-cycle pulse when a load is rejected.
- `tick_lost` output 1: sticky watchdog flag.

## Operation
- **Reset:** all outputs are 0 and the time is 00:00:00. The synchronizer flops and the edge history are 0. The watchdog count is 0 and `armed` is 0.
- **Synchronizer:** `tick_in` passes through `SYNC_STAGES` flops, then one history flop.
- **Edge detection:** an edge is the difference between the last sync stage and the history flop, filtered by `EDGE_MODE`.
- **Arming:** `armed` sets `SYNC_STAGES`+1 cycles after reset release. Edges are suppressed while `armed`=0, so a `tick_in` that is already high at reset does not produce a spurious tick.
- **Tick:** a registered pulse for each qualified edge.
- **Time update on a cycle with `tick`=1 and `set_valid`=0:**
  - `ss` increments in BCD: the low nibble wraps 9→0 and carries into the high nibble.
  - `ss` 59→00 increments `mm` and pulses `min_roll`.
  - `mm` 59→00 increments `hh`.
  - `hh:mm:ss` 23:59:59→00:00:00 pulses `day_roll` together with `min_roll`.
- **Load:**
  - `set_valid` with all fields legal replaces `hh`/`mm`/`ss` on the next edge.
  - A field is illegal if any nibble is >9, `ss`/`mm` is >0x59, or `hh` is >0x23.
  - An illegal load leaves the time unchanged and pulses `load_err`.
  - Load beats tick: a coincident tick still pulses `tick` but is not counted, and it produces no roll pulses.
- **Watchdog:**
  - The counter increments each cycle and clears on `tick`.
  - At `TIMEOUT`-1 it sets `tick_lost` and saturates.
  - `tick_lost_clr` clears the flag and the counter. If a clear and a set coincide, the set wins.
- **Reset mid-operation:** everything returns to reset values immediately. Re-arming then follows the same sequence as at power-up.

## Timing
- **`tick` latency:** an edge of `tick_in` that meets setup before clock edge 0 appears on `tick` in cycle `SYNC_STAGES`+1.
- **Time update latency:**
  - The time changes at the end of the `tick` cycle, so the new `ss` is visible the cycle after `tick`.
  - `min_roll`/`day_roll` are asserted in that same cycle as the new value.
- **Load latency:** 1 cycle from `set_valid` to the new time; `load_err` also follows in 1 cycle.
- **Edge spacing:** `tick_in` edges closer than `SYNC_STAGES`+2 cycles apart are not guaranteed to be counted. The divider never produces such edges.
- **Pulse widths:** every pulse output is exactly one `clk` cycle wide.

## Structure
- **Package `tk_pkg`:**
  - BCD field width 8.
  - Constants `SS_MAX`=8'h59, `MM_MAX`=8'h59, `HH_MAX`=8'h23.
  - A BCD-legality function shared with the alarm-set logic.
- **Sub-module `tick_sync_edge`:** holds the synchronizer, history flop, arming counter and `EDGE_MODE` filter. Its output is the qualified edge pulse.
- **Top level:** contains the BCD counter chain, load/validation logic and watchdog.

## Test plan
- **Reset with `tick_in` held high:** assert `rst`=0 with `tick_in`=1, release, and hold for 20 cycles → `tick` stays 0 and the time stays 00:00:00.
- **Single edge latency:** `SYNC_STAGES`=2, `EDGE_MODE`=0, one `tick_in` rising edge → `tick` high in cycle 3, `ss`=0x01 in cycle 4. The following falling edge → no tick.
- **Day wrap:** load 23:59:58, then drive 2 rising edges → 23:59:59, then 00:00:00 with `min_roll`=`day_roll`=1 for one cycle.
- **Load handling:**
  - Load 0x24:0x00:0x00 → `load_err` pulses and the time is unchanged.
  - Load 0x12:0x3A:0x00 → `load_err` pulses.
  - Legal load coincident with `tick` → the loaded value exactly, no increment.
- **Watchdog:** `TIMEOUT`=10 with no edges → `tick_lost` sets after 10 cycles. Pulse `tick_lost_clr` in the same cycle as a re-timeout → the flag stays 1. A later clear with ticks running → 0.
- **Both-edge mode:** `EDGE_MODE`=1, 4 `tick_in` toggles → `ss` advances by 4. Assert `rst` mid-sequence → all outputs are 0 immediately.
